// File: rtl/serial_tx_port.sv
// TileLink-UL responder that queues bytes written to TXDATA and drains them
// onto a byte-wide valid/ready serial output with an optional inter-byte gap.

package serial_tx_port_pkg;
  typedef struct packed {
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
  } tilelink_a;

  typedef struct packed {
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_valid;
    logic        d_ready;
  } tilelink_d;
endpackage

module serial_tx_port
  import serial_tx_port_pkg::*;
#(
  parameter logic [31:0] addr_mask = 32'hF0000000,
  parameter logic [31:0] addr_tag  = 32'hE0000000,
  parameter int          depth     = 16,
  parameter int          byte_gap  = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  tilelink_a  tick_tla,
  output tilelink_d  bus_tld,
  input  logic       serial_ready,
  output logic       serial_valid,
  output logic [7:0] serial_data
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [7:0]    r_mem [depth];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_gap;
  tilelink_d     r_d;

  tilelink_d w_d_nxt;
  logic      w_hit, w_sel_status, w_full, w_empty;
  logic      w_put, w_get, w_push, w_pop;
  logic [8:0] w_cnt_ext;
  logic      w_unused;

  assign w_unused = ^{tick_tla.a_param, tick_tla.a_ready,
                      tick_tla.a_mask[3:1], tick_tla.a_data[31:8]};

  assign w_hit        = tick_tla.a_valid && ((tick_tla.a_address & addr_mask) == addr_tag);
  assign w_sel_status = tick_tla.a_address[2];
  assign w_full       = (r_count == DEPTH_C);
  assign w_empty      = (r_count == '0);
  assign w_put        = (tick_tla.a_opcode == 3'd0) || (tick_tla.a_opcode == 3'd1);
  assign w_get        = (tick_tla.a_opcode == 3'd4);
  // Full is judged on the start-of-cycle count, so a same-cycle pop never frees a slot.
  assign w_push       = w_hit && w_put && !w_sel_status && tick_tla.a_mask[0] && !w_full;
  assign w_cnt_ext    = 9'(r_count);

  assign serial_valid = !w_empty && (r_gap == 8'd0);
  assign serial_data  = serial_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign w_pop        = serial_valid && serial_ready;
  assign bus_tld      = r_d;

  always_comb begin
    w_d_nxt = '0;
    if (w_hit) begin
      w_d_nxt.d_valid  = 1'b1;
      w_d_nxt.d_ready  = 1'b1;
      w_d_nxt.d_source = tick_tla.a_source;
      w_d_nxt.d_size   = tick_tla.a_size;
      if (w_get) begin
        w_d_nxt.d_opcode = 3'd1;
        if (w_sel_status)
          w_d_nxt.d_data = {16'h0000, w_cnt_ext[7:0], 6'b0, w_empty, w_full};
      end else if (w_put) begin
        w_d_nxt.d_error = !w_sel_status && tick_tla.a_mask[0] && w_full;
      end else begin
        w_d_nxt.d_error = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= tick_tla.a_data[7:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_gap    <= 8'd0;
      r_d      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)                r_gap <= 8'(byte_gap);
      else if (r_gap != 8'd0)   r_gap <= r_gap - 8'd1;
      r_d <= w_d_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx_port.sv
// Bench for serial_tx_port: two instances (gap 0 and gap 3) share one stimulus
// stream and are checked every cycle against a queue-based behavioural model.

module tb_serial_tx_port;
  import serial_tx_port_pkg::*;

  localparam logic [31:0] TX = 32'hE0000000;
  localparam logic [31:0] ST = 32'hE0000004;

  logic       clock = 1'b0;
  logic       reset_n;
  tilelink_a  tla;
  tilelink_d  tld0, tld1;
  logic       serial_ready;
  logic       sv0, sv1;
  logic [7:0] sd0, sd1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  serial_tx_port #(.depth(16), .byte_gap(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .tick_tla(tla), .bus_tld(tld0),
    .serial_ready(serial_ready), .serial_valid(sv0), .serial_data(sd0));

  serial_tx_port #(.depth(16), .byte_gap(3)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .tick_tla(tla), .bus_tld(tld1),
    .serial_ready(serial_ready), .serial_valid(sv1), .serial_data(sd1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: per-instance byte queue (kept as a shifted array), gap countdown,
  // and the response expected to be visible during the current cycle.
  logic [7:0] mq [2][16];
  int         mn [2];
  int         mg [2];
  tilelink_d  me [2];
  logic [7:0] log0[$];
  int         pops1[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mg[k] = 0; me[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      tilelink_d r;
      logic pop, push, full, hit;
      full = (mn[k] == 16);
      pop  = (mn[k] > 0) && (mg[k] == 0) && serial_ready;
      hit  = tla.a_valid && (tla.a_address[31:28] == 4'hE);
      push = 1'b0;
      r    = '0;
      if (hit) begin
        r.d_valid = 1'b1; r.d_ready = 1'b1;
        r.d_source = tla.a_source; r.d_size = tla.a_size;
        if (tla.a_opcode == 3'd0 || tla.a_opcode == 3'd1) begin
          if (!tla.a_address[2] && tla.a_mask[0]) begin
            if (full) r.d_error = 1'b1;
            else      push = 1'b1;
          end
        end else if (tla.a_opcode == 3'd4) begin
          r.d_opcode = 3'd1;
          if (tla.a_address[2])
            r.d_data = {16'h0, 8'(mn[k] % 256), 6'b0, (mn[k] == 0), full};
        end else begin
          r.d_error = 1'b1;
        end
      end
      me[k] = r;
      if (pop) begin
        for (int i = 0; i < 15; i++) mq[k][i] = mq[k][i+1];
        mn[k]--;
        mg[k] = (k == 0) ? 0 : 3;
      end else if (mg[k] > 0) begin
        mg[k]--;
      end
      if (push) begin
        mq[k][mn[k]] = tla.a_data[7:0];
        mn[k]++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      if (!reset_n) model_reset();
      for (int k = 0; k < 2; k++) begin
        logic msv;
        msv = (mn[k] > 0) && (mg[k] == 0);
        chk($sformatf("bus_tld dut%0d", k), (k == 0) ? tld0 : tld1, me[k]);
        chk($sformatf("serial_valid dut%0d", k), (k == 0) ? sv0 : sv1, msv);
        if (msv) chk($sformatf("serial_data dut%0d", k), (k == 0) ? sd0 : sd1, mq[k][0]);
      end
      if (reset_n) begin
        if (sv0 && serial_ready) log0.push_back(sd0);
        if (sv1 && serial_ready) pops1.push_back(cyc);
        model_step();
      end
    end
  end

  task automatic tl_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [7:0] dat,
                        input logic [7:0] src);
    tla = '0;
    tla.a_opcode  = op;
    tla.a_address = addr;
    tla.a_mask    = mask;
    tla.a_data    = {24'hA5A5A5, dat};
    tla.a_source  = src;
    tla.a_size    = 3'd2;
    tla.a_ready   = 1'b1;
    tla.a_valid   = 1'b1;
    @(posedge clock); #1;
    tla.a_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [2:0] op; logic [31:0] addr; logic [3:0] mask;
    logic ev; logic [2:0] eop; logic eerr; logic [31:0] edata;
  } vec_t;
  vec_t vt [6];

  initial begin
    int putcyc;
    reset_n = 1'b0; tla = '0; serial_ready = 1'b0;
    vt[0] = '{3'd0, TX,            4'h0, 1'b1, 3'd0, 1'b0, 32'h0};
    vt[1] = '{3'd0, ST,            4'h1, 1'b1, 3'd0, 1'b0, 32'h0};
    vt[2] = '{3'd4, TX,            4'h0, 1'b1, 3'd1, 1'b0, 32'h0};
    vt[3] = '{3'd2, TX,            4'h1, 1'b1, 3'd0, 1'b1, 32'h0};
    vt[4] = '{3'd0, 32'h10000000,  4'h1, 1'b0, 3'd0, 1'b0, 32'h0};
    vt[5] = '{3'd4, 32'hE0000007,  4'h0, 1'b1, 3'd1, 1'b0, 32'h2};

    repeat (3) @(posedge clock);
    #1;
    chk("reset bus_tld", tld0, 64'h0);
    chk("reset serial_valid", sv0, 1'b0);
    chk("reset serial_data", sd0, 8'h00);
    reset_n = 1'b1;
    idle(1);

    tl_req(3'd4, ST, 4'h0, 8'h00, 8'h11);
    chk("idle status d_valid", tld0.d_valid, 1'b1);
    chk("idle status d_opcode", tld0.d_opcode, 3'd1);
    chk("idle status d_data", tld0.d_data, 32'h00000002);
    chk("idle status d_source", tld0.d_source, 8'h11);

    serial_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tl_req(3'd0, TX, 4'h1, 8'h41 + 8'(i), 8'h20);
      chk("put ack d_error", tld0.d_error, 1'b0);
      chk("put ack d_opcode", tld0.d_opcode, 3'd0);
      chk("stream byte", sd0, 8'h41 + 8'(i));
    end
    idle(20);

    serial_ready = 1'b0;
    log0.delete();
    for (int i = 0; i < 17; i++) begin
      tl_req(3'd0, TX, 4'h1, 8'(i), 8'h30);
      chk($sformatf("fill %0d err dut0", i), tld0.d_error, (i == 16));
      chk($sformatf("fill %0d err dut1", i), tld1.d_error, (i == 16));
    end
    tl_req(3'd4, ST, 4'h0, 8'h00, 8'h31);
    chk("full status dut0", tld0.d_data, 32'h00001001);
    chk("full status dut1", tld1.d_data, 32'h00001001);

    serial_ready = 1'b1;
    tl_req(3'd0, TX, 4'h1, 8'h99, 8'h40);
    chk("full put+pop err dut0", tld0.d_error, 1'b1);
    chk("full put+pop err dut1", tld1.d_error, 1'b1);
    tl_req(3'd4, ST, 4'h0, 8'h00, 8'h41);
    chk("after pop status dut0", tld0.d_data, 32'h00000F00);
    chk("after pop status dut1", tld1.d_data, 32'h00000F00);
    idle(80);
    chk("drain count", log0.size(), 16);
    for (int i = 0; i < 16 && i < log0.size(); i++)
      chk($sformatf("drain byte %0d", i), log0[i], 8'(i));

    pops1.delete();
    putcyc = cyc;
    for (int i = 0; i < 4; i++) tl_req(3'd0, TX, 4'h1, 8'hB0 + 8'(i), 8'h50);
    idle(20);
    chk("gap pop count", pops1.size(), 4);
    for (int i = 0; i < 4 && i < pops1.size(); i++)
      chk($sformatf("gap pop cycle %0d", i), pops1[i], putcyc + 1 + 4 * i);

    serial_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tl_req(vt[i].op, vt[i].addr, vt[i].mask, 8'h77, 8'h60 + 8'(i));
      chk($sformatf("vec%0d d_valid", i), tld0.d_valid, vt[i].ev);
      chk($sformatf("vec%0d d_opcode", i), tld0.d_opcode, vt[i].eop);
      chk($sformatf("vec%0d d_error", i), tld0.d_error, vt[i].eerr);
      chk($sformatf("vec%0d d_data", i), tld0.d_data, vt[i].edata);
    end

    for (int i = 0; i < 5; i++) tl_req(3'd0, TX, 4'h1, 8'hC0 + 8'(i), 8'h70);
    tl_req(3'd4, ST, 4'h0, 8'h00, 8'h71);
    chk("pre-reset d_valid", tld0.d_valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("async reset d_valid dut0", tld0.d_valid, 1'b0);
    chk("async reset d_valid dut1", tld1.d_valid, 1'b0);
    chk("async reset serial_valid dut0", sv0, 1'b0);
    chk("async reset serial_valid dut1", sv1, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    idle(1);
    tl_req(3'd4, ST, 4'h0, 8'h00, 8'h72);
    chk("post-reset status dut0", tld0.d_data, 32'h00000002);
    chk("post-reset status dut1", tld1.d_data, 32'h00000002);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
